// File: rtl/coder_out_packer.sv
// Output packer for the encoder stack: frames the three encoder lanes into a FIFO and
// drains them as parallel (all lanes per word) or serial (one lane per word) blocks.
module coder_out_packer #(
  parameter int DATA_W      = 8,
  parameter int NUM_STREAMS = 3,
  parameter int FIFO_DEPTH  = 16,
  parameter int SMALL_BEATS = 132,
  parameter int LARGE_BEATS = 768
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic                             in_start,
  input  logic                             in_blk_size,
  input  logic                             in_mode,
  input  logic [NUM_STREAMS*DATA_W-1:0]    in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_STREAMS*DATA_W-1:0]    out_data,
  output logic                             out_sof,
  output logic                             out_eof,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             overflow,
  output logic                             err_framing
);
  localparam int DW     = NUM_STREAMS * DATA_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = $clog2(FIFO_DEPTH + 1);
  localparam int LANE_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BLOCK = 1'b1;

  typedef struct packed {
    logic          mode;
    logic          sof;
    logic          eof;
    logic [DW-1:0] data;
  } entry_t;

  // write-side framing FSM
  logic [0:0]  r_state, w_nxt_state;
  logic [15:0] r_beat_cnt, w_nxt_cnt;
  logic [15:0] r_blk_len, w_nxt_len, w_start_len;
  logic        r_mode, w_nxt_mode;
  logic        w_wr_en, w_frame_err, w_last_beat;
  entry_t      w_wr_entry;

  assign w_start_len = in_blk_size ? 16'(LARGE_BEATS) : 16'(SMALL_BEATS);
  assign w_last_beat = (r_beat_cnt == r_blk_len - 16'd1);

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_entry  = '0;
    w_frame_err = 1'b0;
    w_nxt_state = r_state;
    w_nxt_cnt   = r_beat_cnt;
    w_nxt_len   = r_blk_len;
    w_nxt_mode  = r_mode;
    if (in_valid) begin
      if (in_start) begin
        // a start inside a block abandons the old block without an eof
        w_frame_err     = (r_state == S_BLOCK);
        w_wr_en         = 1'b1;
        w_wr_entry.mode = in_mode;
        w_wr_entry.sof  = 1'b1;
        w_wr_entry.eof  = (w_start_len == 16'd1);
        w_wr_entry.data = in_data;
        w_nxt_len       = w_start_len;
        w_nxt_mode      = in_mode;
        w_nxt_cnt       = 16'd1;
        w_nxt_state     = (w_start_len == 16'd1) ? S_IDLE : S_BLOCK;
      end else if (r_state == S_IDLE) begin
        w_frame_err = 1'b1;
      end else begin
        w_wr_en         = 1'b1;
        w_wr_entry.mode = r_mode;
        w_wr_entry.eof  = w_last_beat;
        w_wr_entry.data = in_data;
        if (w_last_beat) w_nxt_state = S_IDLE;
        else             w_nxt_cnt   = r_beat_cnt + 16'd1;
      end
    end
  end

  // FIFO and holding register
  entry_t            r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [LW-1:0]     r_level;
  entry_t            r_hold;
  logic              r_hold_valid;
  logic [LANE_W-1:0] r_lane;
  logic              w_full, w_empty, w_push, w_pop, w_consume, w_hold_last;

  assign w_full      = (r_level == LW'(FIFO_DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_consume   = r_hold_valid & out_ready;
  assign w_hold_last = ~r_hold.mode | (r_lane == LANE_W'(NUM_STREAMS - 1));
  assign w_pop       = ~w_empty & (~r_hold_valid | (w_consume & w_hold_last));
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push      = w_wr_en & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wr_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_beat_cnt   <= '0;
      r_blk_len    <= '0;
      r_mode       <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_lane       <= '0;
      overflow     <= 1'b0;
      err_framing  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_beat_cnt <= w_nxt_cnt;
      r_blk_len  <= w_nxt_len;
      r_mode     <= w_nxt_mode;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      if (w_wr_en & ~w_push) overflow    <= 1'b1;
      if (w_frame_err)       err_framing <= 1'b1;
      if (w_pop) begin
        r_hold       <= r_mem[r_rptr];
        r_hold_valid <= 1'b1;
        r_lane       <= '0;
      end else if (w_consume) begin
        if (w_hold_last) r_hold_valid <= 1'b0;
        else             r_lane       <= r_lane + LANE_W'(1);
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (r_hold_valid) begin
      if (r_hold.mode) out_data[DATA_W-1:0] = r_hold.data[int'(r_lane)*DATA_W +: DATA_W];
      else             out_data = r_hold.data;
    end
  end

  assign out_valid  = r_hold_valid;
  assign out_sof    = r_hold_valid & r_hold.sof & (~r_hold.mode | (r_lane == '0));
  assign out_eof    = r_hold_valid & r_hold.eof & w_hold_last;
  assign fifo_level = r_level;

endmodule
